ifu_ir: RTL

- Multi-cycle fetch stage with instruction register (IR), directly upstream of the immediate sign-extension unit.
- Issues the PC to instruction memory over a valid/ready request/response handshake and latches the returned instruction into the IR.
- Pre-decodes the opcode into the 5-bit one-hot immediate-format select {S,B,I,J,U}, which feeds the sign-extension unit alongside the IR.
- Holds the IR stable until the execute side signals completion, then loads the next PC.

---
 rtl/ifu_ir_if.sv | 27 ++
 rtl/ifu_ir.sv | 55 +++++
 2 files changed

// File: rtl/ifu_ir_if.sv
// ifu_ir_if: fetch-stage bundle (memory handshake, execute handoff, IR outputs).
// inst_cnt is present only when IFU_INST_CNT_EN is defined.
interface ifu_ir_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] next_pc;
  logic        ir_done;
  logic [31:0] inst;
  logic [4:0]  imm_sel;
  logic        ir_valid;
`ifdef IFU_INST_CNT_EN
  logic [31:0] inst_cnt;
  modport master(output PC, Inst_Req_Valid, Inst_Ready, inst, imm_sel, ir_valid, inst_cnt,
                 input Inst_Req_Ready, Instruction, Inst_Valid, next_pc, ir_done);
  modport slave(input PC, Inst_Req_Valid, Inst_Ready, inst, imm_sel, ir_valid, inst_cnt,
                output Inst_Req_Ready, Instruction, Inst_Valid, next_pc, ir_done);
`else
  modport master(output PC, Inst_Req_Valid, Inst_Ready, inst, imm_sel, ir_valid,
                 input Inst_Req_Ready, Instruction, Inst_Valid, next_pc, ir_done);
  modport slave(input PC, Inst_Req_Valid, Inst_Ready, inst, imm_sel, ir_valid,
                output Inst_Req_Ready, Instruction, Inst_Valid, next_pc, ir_done);
`endif
endinterface

// File: rtl/ifu_ir.sv
// ifu_ir: multi-cycle fetch with instruction register and immediate-format pre-decode.
// Optional fetch counter inst_cnt enabled by IFU_INST_CNT_EN.
module ifu_ir #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  ifu_ir_if.master b
);
  typedef enum logic [1:0] {INIT, IF, IW, HOLD} state_t;
  state_t      state, state_n;
  logic [6:0]  op;
  logic [4:0]  dec;
  logic        load;
  assign op = b.Instruction[6:0];
  assign load = (state == IW) && b.Inst_Valid;
  always_comb begin
    dec = (op == 7'h37 || op == 7'h17) ? 5'b00001 :
          (op == 7'h6f) ? 5'b00010 :
          (op == 7'h13 || op == 7'h03 || op == 7'h67) ? 5'b00100 :
          (op == 7'h63) ? 5'b01000 :
          (op == 7'h23) ? 5'b10000 : 5'b00000;
  end
  always_comb begin
    state_n = state == INIT ? IF :
              state == IF   ? (b.Inst_Req_Ready ? IW : IF) :
              state == IW   ? (b.Inst_Valid ? HOLD : IW) :
                              (b.ir_done ? IF : HOLD);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT;
      b.PC      <= RESET_PC;
      b.inst    <= '0;
      b.imm_sel <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        b.inst    <= b.Instruction;
        b.imm_sel <= dec;
      end
      if (state == HOLD && b.ir_done) b.PC <= b.next_pc & ~32'h3;
    end
  end
  // handshake flags are pure state decodes so they never depend on same-cycle inputs
  assign b.Inst_Req_Valid = state == IF;
  assign b.Inst_Ready     = state == IW;
  assign b.ir_valid       = state == HOLD;
`ifdef IFU_INST_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) b.inst_cnt <= '0;
    else if (load) b.inst_cnt <= b.inst_cnt + 32'd1;
  end
`endif
endmodule
